// File: rtl/prog_sequencer.sv
// Program-level fetch controller: selects a resident program, owns the PC,
// applies branch targets and enforces a RUN-cycle watchdog.
module prog_sequencer #(
    parameter logic [9:0]  START1     = 10'd0,
    parameter logic [9:0]  START2     = 10'd256,
    parameter logic [9:0]  START3     = 10'd512,
    parameter logic [15:0] MAX_CYCLES = 16'd65535
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  ProgSel,
    input  logic        BranchTaken,
    input  logic [9:0]  Target,
    input  logic        Halt,
    output logic [1:0]  ProgState,
    output logic [9:0]  PC,
    output logic        Busy,
    output logic        Done,
    output logic        Timeout,
    output logic [15:0] CycleCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [15:0] LAST_CYCLE = MAX_CYCLES - 16'd1;

    state_t      state_q, state_d;
    logic [9:0]  pc_q, pc_d;
    logic [1:0]  prog_q, prog_d;
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic [15:0] cnt_inc;

    // Saturating increment; the watchdog normally ends the run long before this matters.
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        pc_d      = pc_q;
        prog_d    = prog_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;

        unique case (state_q)
            S_IDLE: begin
                if (Start && (ProgSel != 2'd0)) begin
                    state_d   = S_LOAD;
                    prog_d    = ProgSel;
                    cnt_d     = 16'd0;
                    timeout_d = 1'b0;
                end
            end
            S_LOAD: begin
                unique case (prog_q)
                    2'd1:    pc_d = START1;
                    2'd2:    pc_d = START2;
                    default: pc_d = START3;
                endcase
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (Halt) begin
                    state_d = S_DONE;
                end else if (cnt_q == LAST_CYCLE) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else if (BranchTaken) begin
                    pc_d = Target;
                end else begin
                    pc_d = pc_q + 10'd1;
                end
            end
            S_DONE: begin
                // Four-phase handshake: Start must drop before another run can begin.
                if (!Start) begin
                    state_d   = S_IDLE;
                    prog_d    = 2'd0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= 10'd0;
            prog_q    <= 2'd0;
            cnt_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            prog_q    <= prog_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign ProgState  = prog_q;
    assign PC         = pc_q;
    assign Busy       = (state_q == S_LOAD) || (state_q == S_RUN);
    assign Done       = (state_q == S_DONE);
    assign Timeout    = timeout_q;
    assign CycleCount = cnt_q;

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Program-level fetch controller. Selects one of three resident programs, drives the 2-bit ProgState consumed by the branch-target lookup table, and owns the 10-bit PC.
- Sequences each program: start, run, halt, done.
- Applies the lookup-table Target on taken branches and enforces a cycle-count watchdog.
- Sits between the testbench/top-level start handshake and the instruction ROM / branch-target LUT.

Parameters:
- START1, 10'd0, PC load value for program 1
- START2, 10'd256, PC load value for program 2
- START3, 10'd512, PC load value for program 3
- MAX_CYCLES, 16'd65535, RUN cycles allowed before forced timeout

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  request to run program selected by ProgSel; level, held until Done seen
- ProgSel  input  2  program number 1..3; 0 is invalid
- BranchTaken  input  1  decode/ALU says current instruction branches (valid in RUN only)
- Target  input  10  absolute branch target from the LUT for the current instruction
- Halt  input  1  decode says current instruction is the program's halt
- ProgState  output  2  active program number to the LUT; 0 when no program is active
- PC  output  10  instruction address to the ROM
- Busy  output  1  high in LOAD and RUN
- Done  output  1  high in DONE
- Timeout  output  1  high in DONE when the watchdog, not Halt, ended the run
- CycleCount  output  16  RUN cycles executed in the current/last program

Behaviour:
- Reset (async, any state): state=IDLE, ProgState=0, PC=0, Busy=0, Done=0, Timeout=0, CycleCount=0. Takes effect immediately, including mid-RUN. The first edge after Reset deasserts is evaluated from IDLE.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Start=1 with ProgSel in 1..3: next=LOAD; latch ProgState=ProgSel; CycleCount=0; Timeout=0.
  - Start=1 with ProgSel=0: ignored, stay IDLE.
  - PC holds its value.
- LOAD (exactly 1 cycle): PC <= START1/2/3 per latched ProgState; next=RUN.
  - Latency: Start sampled at edge N, PC = start address after edge N+1, first RUN cycle follows.
- RUN, evaluated each edge in priority order:
  1. Halt=1: next=DONE; PC held; CycleCount+1.
  2. CycleCount == MAX_CYCLES-1: next=DONE; Timeout=1; PC held; CycleCount+1.
  3. BranchTaken=1: PC <= Target; CycleCount+1.
  4. Otherwise: PC <= PC+1 modulo 1024 (10'h3FF wraps to 0); CycleCount+1.
  - Halt takes priority over a simultaneous BranchTaken and over the watchdog; Timeout stays 0 if Halt and the limit coincide.
- DONE:
  - Done=1; PC, CycleCount, Timeout and ProgState frozen.
  - When Start=0: next=IDLE; ProgState=0. Done and Timeout clear on leaving DONE.
  - A new run needs Start to go low, then high again (4-phase handshake).
- Start and ProgSel changes during LOAD/RUN are ignored; ProgState is stable for the whole run.
- CycleCount saturates at 16'hFFFF and never wraps. It is unreachable beyond MAX_CYCLES in any case.
- All outputs are registered or decoded from state; no input-to-output combinational path.
- BranchTaken and Target are ignored outside RUN.

Test Plan:
- Reset mid-RUN: program 2 running, PC=10'd260, assert Reset → same cycle ProgState=0, PC=0, Busy=0; after release, stays IDLE with Start low.
- Basic run: Start=1, ProgSel=2'd1, Halt asserted on 5th RUN cycle → LOAD gives PC=0; PC 0,1,2,3,4; Done=1, CycleCount=5, Timeout=0, ProgState=1; drop Start → IDLE, ProgState=0, Done=0.
- Branch and wrap:
  - Program 3 with START3 overridden to 10'd1022, no branch → PC 1022, 1023, 0.
  - BranchTaken with Target=10'd600 → next PC=600.
  - BranchTaken and Halt in the same cycle → DONE, PC unchanged.
- Watchdog: MAX_CYCLES=8, Halt never asserted → DONE after exactly 8 RUN cycles, CycleCount=8, Timeout=1.
- Invalid and ignored requests:
  - Start with ProgSel=0 → stays IDLE, Busy=0.
  - ProgSel changed 1→3 mid-RUN → ProgState stays 1.
  - Start held high through DONE → remains DONE until Start drops.
